// File: rtl/mdc_tx.sv
// Transmitter for the MDC determinant engine: collects a 4x4 matrix plus mode,
// Hamming-encodes every word (with optional bit-flip injection), streams it, then awaits the result.
module mdc_tx #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned N_ENT   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld_valid,
  output logic           ld_ready,
  input  logic [4:0]     ld_mode,
  input  logic [3:0]     ld_mode_err,
  input  logic [10:0]    ld_data,
  input  logic [3:0]     ld_data_err,
  output logic           in_valid,
  output logic [8:0]     in_mode,
  output logic [14:0]    in_data,
  input  logic           mdc_out_valid,
  input  logic [206:0]   mdc_out_data,
  output logic           busy,
  output logic           done,
  output logic           timeout,
  output logic [206:0]   result
);

  localparam int unsigned MODE_W = 5;
  localparam int unsigned MCW_W  = 9;
  localparam int unsigned DAT_W  = 11;
  localparam int unsigned DCW_W  = 15;
  localparam int unsigned ERR_W  = 4;
  localparam int unsigned RES_W  = 207;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = ($clog2(TIMEOUT) > IDX_W) ? $clog2(TIMEOUT) : IDX_W;
  localparam logic [CNT_W-1:0] LAST_ENT  = CNT_W'(N_ENT - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  // Even-parity Hamming encode of an nd-bit word into an n-bit codeword, position 1 at the MSB,
  // followed by inversion of position err (0 or out of range leaves the word untouched).
  function automatic logic [DCW_W-1:0] ham_enc(input logic [DAT_W-1:0] d, input int unsigned n,
                                               input int unsigned nd, input logic [ERR_W-1:0] err);
    logic [15:0]      pos;
    logic [DCW_W-1:0] cw;
    int unsigned      j;
    pos = '0;
    cw  = '0;
    j   = nd;
    for (int unsigned p = 1; p <= 15; p++) begin
      if (p <= n && (p & (p - 1)) != 0) begin
        j = j - 1;
        if ((d & (DAT_W'(1) << j)) != '0) begin
          pos = pos | (16'(1) << p);
          for (int unsigned k = 0; k < 4; k++)
            if (((p >> k) & 1) != 0) pos = pos ^ (16'(1) << (1 << k));
        end
      end
    end
    if (err != '0 && 32'(err) <= n) pos = pos ^ (16'(1) << err);
    for (int unsigned p = 1; p <= 15; p++)
      if (p <= n && (pos & (16'(1) << p)) != '0) cw = cw | (DCW_W'(1) << (n - p));
    return cw;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MCW_W-1:0]     mode_cw_q, mode_cw_d;
  logic [DCW_W-1:0]     buf_q [N_ENT];
  logic [DCW_W-1:0]     data_cw_c;
  logic [MCW_W-1:0]     mode_cw_c;
  logic [IDX_W-1:0]     idx_c, idx_nxt_c;
  logic                 accept_c;
  logic                 ld_ready_d, in_valid_d, busy_d, done_d, timeout_d;
  logic [MCW_W-1:0]     in_mode_d;
  logic [DCW_W-1:0]     in_data_d;
  logic [RES_W-1:0]     result_d;

  assign data_cw_c = ham_enc(ld_data, DCW_W, DAT_W, ld_data_err);
  assign mode_cw_c = MCW_W'(ham_enc(DAT_W'(ld_mode), MCW_W, MODE_W, ld_mode_err));
  assign idx_c     = cnt_q[IDX_W-1:0];
  assign idx_nxt_c = idx_c + IDX_W'(1);

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_cw_d  = mode_cw_q;
    accept_c   = 1'b0;
    in_valid_d = 1'b0;
    in_mode_d  = '0;
    in_data_d  = '0;
    done_d     = 1'b0;
    timeout_d  = timeout;
    result_d   = result;
    case (state_q)
      S_IDLE: begin
        if (ld_valid && ld_ready) begin
          accept_c = 1'b1;
          if (cnt_q == '0) mode_cw_d = mode_cw_c;
          if (cnt_q == LAST_ENT) begin
            state_d    = S_SEND;
            cnt_d      = '0;
            in_valid_d = 1'b1;
            in_mode_d  = mode_cw_q;
            in_data_d  = buf_q[0];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_SEND: begin
        if (cnt_q == LAST_ENT) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          in_valid_d = 1'b1;
          in_data_d  = buf_q[idx_nxt_c];
        end
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle takes priority over the timeout.
        if (mdc_out_valid) begin
          state_d   = S_DONE;
          result_d  = mdc_out_data;
          timeout_d = 1'b0;
          done_d    = 1'b1;
        end else if (cnt_q == LAST_WAIT) begin
          state_d   = S_DONE;
          result_d  = '0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    ld_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mode_cw_q <= '0;
      ld_ready  <= 1'b0;
      in_valid  <= 1'b0;
      in_mode   <= '0;
      in_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      result    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_cw_q <= mode_cw_d;
      ld_ready  <= ld_ready_d;
      in_valid  <= in_valid_d;
      in_mode   <= in_mode_d;
      in_data   <= in_data_d;
      busy      <= busy_d;
      done      <= done_d;
      timeout   <= timeout_d;
      result    <= result_d;
    end
  end

  // Word buffer: contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept_c) buf_q[idx_c] <= data_cw_c;
  end

endmodule

// File: doc/mdc_tx.md
Name: mdc_tx

Overview:
- Initiator/transmitter for the MDC determinant engine.
- Collects one 4x4 matrix (16 signed 11-bit entries) plus a 5-bit mode word from an upstream loader.
- Hamming-encodes each word and drives the 16-cycle encoded stream the engine expects, with optional per-word single-bit error injection to exercise the engine's correction.
- Then waits for the engine's result and reports it upstream. This is the test-harness and system-side driver.

Parameters:
- TIMEOUT, 1000, max cycles in WAIT before giving up.
- N_ENT, 16, entries per matrix (fixed at 16; not to be overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  upstream entry valid.
- ld_ready  out  1  block accepts an entry this cycle.
- ld_mode  in  5  raw mode; sampled only with entry 0.
- ld_mode_err  in  4  mode bit-flip position, 0 = none, 1..9 = flip; sampled with entry 0.
- ld_data  in  11  raw signed matrix entry, row-major.
- ld_data_err  in  4  data bit-flip position, 0 = none, 1..15 = flip.
- in_valid  out  1  to engine.
- in_mode  out  9  encoded mode to engine.
- in_data  out  15  encoded entry to engine.
- mdc_out_valid  in  1  engine result valid.
- mdc_out_data  in  207  engine result.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  qualifies done: result not received.
- result  out  207  captured engine result, held until next done.

Behaviour:
- Hamming code definition (even parity):
  - Codeword positions 1..n; position p maps to bit [n-p], so position 1 is the MSB. n = 9 for mode, n = 15 for data.
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits fill the remaining positions in ascending order, data MSB first.
  - Parity at position 2^k = XOR of all non-parity positions whose index has bit k set.
- Error injection: when the err field is k ≠ 0, position k of the codeword is inverted after encoding. mode_err values 10..15 are treated as 0.
- State machine: IDLE -> SEND -> WAIT -> DONE -> IDLE.
- IDLE:
  - ld_ready = 1.
  - Each ld_valid & ld_ready stores the encoded, error-applied word into a 16-deep buffer at index cnt, and increments cnt.
  - Entry 0 also latches the encoded mode.
  - The accept of entry 15 moves to SEND with cnt = 0; ld_ready drops the next cycle.
- SEND: 16 consecutive cycles.
  - in_valid = 1; in_data = buf[cnt].
  - in_mode = encoded mode when cnt == 0, else 0.
  - First in_valid cycle is the cycle immediately after the 16th accept.
  - No gaps; after cnt == 15 move to WAIT.
- WAIT:
  - Counts cycles, starting from 0.
  - On mdc_out_valid: capture mdc_out_data into result, go to DONE.
  - If the count reaches TIMEOUT-1 without a result: result <= 0, timeout flag set, go to DONE.
  - If mdc_out_valid and the final timeout cycle coincide, the result wins and timeout = 0.
- DONE: done = 1 for exactly one cycle, then IDLE; cnt cleared; result and timeout held.
- Outside SEND: in_valid = 0, in_mode = 0, in_data = 0, all registered (no glitches).
- mdc_out_valid outside WAIT is ignored.
- ld_valid outside IDLE is ignored; upstream must hold data until ld_ready.
- Reset value of every output is 0 (ld_ready = 0 during reset, 1 the first cycle after reset release). Buffer contents are don't-care.
- Reset mid-operation: immediate return to IDLE, partial matrix discarded, stream aborts with in_valid = 0 at once.

Test Plan:
- Mode 5'b00100, entries all 11'd1, no errors:
  - in_mode = 9'b010101000 on the first in_valid cycle only, 0 afterwards.
  - in_data = 15'b110100010000001 for all 16 cycles.
  - in_valid high exactly 16 cycles, starting the cycle after the 16th accept.
- Entries 11'h7FF and 11'h000 alternating -> in_data alternates 15'h7FFF / 15'h0000.
- Same stream with ld_data_err = 15 on entry 0, ld_mode_err = 2:
  - Entry 0 sent as 15'h7FFE.
  - Mode sent as 9'b000101000.
  - Other words unchanged.
- Engine model returns mdc_out_valid 20 cycles after the last in_valid, data 207'h1234 -> result = 207'h1234, done pulses 1 cycle, timeout = 0, busy falls with IDLE.
- TIMEOUT = 8, no mdc_out_valid -> done after 8 WAIT cycles with timeout = 1, result = 0.
- rst_n asserted after 10 of 16 SEND cycles:
  - in_valid = 0 immediately.
  - After release, ld_ready = 1.
  - A new 16-entry load transmits correctly.
